// File: rtl/mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_ctrl : byte-serial load/store responder for a byte-wide, 1-cycle     |
// |            read-latency synchronous RAM (little-endian)                  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module mem_ctrl #(
  parameter int RAM_AW = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ram_read,
  input  logic              ram_write,
  input  logic [31:0]       ram_addr,
  input  logic [31:0]       ram_data_i,
  input  logic [2:0]        ram_length,
  input  logic              ram_signed,
  output logic              ram_busy,
  output logic              ram_ready,
  output logic [31:0]       ram_data_o,
  output logic [RAM_AW-1:0] mem_a,
  output logic [7:0]        mem_dout,
  input  logic [7:0]        mem_din,
  output logic              mem_wr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state, w_state;
  logic [2:0]        r_cnt, w_cnt, w_cnt_inc;
  logic [2:0]        r_len, w_len, w_len_dec;
  logic              r_sgn, w_sgn;
  logic [RAM_AW-1:0] r_addr, w_addr, w_addr_step, w_mem_a;
  logic [3:0][7:0]   r_data, w_data, r_bytes, w_bytes, w_cap;
  logic [31:0]       w_ext, w_data_o;
  logic [7:0]        w_mem_dout;
  logic              w_mem_wr;
  logic              w_unused;

  // Upper address bits are intentionally dropped: the RAM space wraps.
  assign w_unused    = &{1'b0, ram_addr[31:RAM_AW]};
  assign w_cnt_inc   = r_cnt + 3'd1;
  assign w_addr_step = r_addr + RAM_AW'(w_cnt_inc);

  always_comb begin
    case (ram_length)
      3'd1:    w_len_dec = 3'd1;
      3'd2:    w_len_dec = 3'd2;
      default: w_len_dec = 3'd4;
    endcase
  end

  // Byte buffer with the byte arriving this cycle merged in, so the final
  // byte can feed the result on the same edge it is captured.
  always_comb begin
    w_cap = r_bytes;
    if (r_cnt != 3'd0) w_cap[r_cnt[1:0] - 2'd1] = mem_din;
  end

  always_comb begin
    case (r_len)
      3'd1:    w_ext = {{24{r_sgn & w_cap[0][7]}}, w_cap[0]};
      3'd2:    w_ext = {{16{r_sgn & w_cap[1][7]}}, w_cap[1], w_cap[0]};
      default: w_ext = w_cap;
    endcase
  end

  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_len      = r_len;
    w_sgn      = r_sgn;
    w_addr     = r_addr;
    w_data     = r_data;
    w_bytes    = r_bytes;
    w_mem_a    = mem_a;
    w_mem_dout = mem_dout;
    w_mem_wr   = 1'b0;
    w_data_o   = ram_data_o;
    case (r_state)
      IDLE: begin
        if (ram_write) begin
          w_state    = WR;
          w_cnt      = 3'd0;
          w_len      = w_len_dec;
          w_addr     = ram_addr[RAM_AW-1:0];
          w_data     = ram_data_i;
          w_mem_a    = ram_addr[RAM_AW-1:0];
          w_mem_dout = ram_data_i[7:0];
          w_mem_wr   = 1'b1;
          w_data_o   = 32'd0;
        end else if (ram_read) begin
          w_state  = RD;
          w_cnt    = 3'd0;
          w_len    = w_len_dec;
          w_sgn    = ram_signed;
          w_addr   = ram_addr[RAM_AW-1:0];
          w_mem_a  = ram_addr[RAM_AW-1:0];
          w_data_o = 32'd0;
        end
      end
      RD: begin
        w_bytes = w_cap;
        if (r_cnt == r_len) begin
          w_state  = DONE;
          w_data_o = w_ext;
        end else begin
          w_cnt = w_cnt_inc;
          if (w_cnt_inc < r_len) w_mem_a = w_addr_step;
        end
      end
      WR: begin
        if (r_cnt == r_len - 3'd1) begin
          w_state = DONE;
        end else begin
          w_cnt      = w_cnt_inc;
          w_mem_a    = w_addr_step;
          w_mem_dout = r_data[w_cnt_inc[1:0]];
          w_mem_wr   = 1'b1;
        end
      end
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_len      <= 3'd0;
      r_sgn      <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_bytes    <= '0;
      ram_busy   <= 1'b0;
      ram_ready  <= 1'b0;
      ram_data_o <= 32'd0;
      mem_a      <= '0;
      mem_dout   <= 8'd0;
      mem_wr     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_len      <= w_len;
      r_sgn      <= w_sgn;
      r_addr     <= w_addr;
      r_data     <= w_data;
      r_bytes    <= w_bytes;
      ram_busy   <= (w_state != IDLE);
      ram_ready  <= (w_state == DONE);
      ram_data_o <= w_data_o;
      mem_a      <= w_mem_a;
      mem_dout   <= w_mem_dout;
      mem_wr     <= w_mem_wr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_ctrl : randomized self-checking bench for mem_ctrl                |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mem_ctrl;
  localparam int AW   = 17;
  localparam int SIZE = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_read, ram_write;
  logic [31:0]   ram_addr, ram_data_i;
  logic [2:0]    ram_length;
  logic          ram_signed;
  logic          ram_busy, ram_ready;
  logic [31:0]   ram_data_o;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_dout;
  logic [7:0]    mem_din;
  logic          mem_wr;

  logic [7:0] ram     [SIZE];
  logic [7:0] ref_mem [SIZE];

  int n_vec = 0;
  int n_err = 0;

  mem_ctrl #(.RAM_AW(AW)) dut (
    .clk(clk), .reset(reset),
    .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_data_i(ram_data_i),
    .ram_length(ram_length), .ram_signed(ram_signed),
    .ram_busy(ram_busy), .ram_ready(ram_ready), .ram_data_o(ram_data_o),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_din(mem_din), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // Synchronous byte RAM, read-first, one cycle read latency.
  always @(posedge clk) begin
    mem_din <= ram[mem_a];
    if (mem_wr) ram[mem_a] = mem_dout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int len_n(input logic [2:0] l);
    return (l == 3'd1) ? 1 : ((l == 3'd2) ? 2 : 4);
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input logic [2:0] l,
                                             input logic s);
    int          n = len_n(l);
    logic [31:0] v = 32'd0;
    for (int i = 0; i < n; i++)
      v = v | (32'(ref_mem[(a + 32'(i)) % SIZE]) << (8 * i));
    if (s && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic poke(input int a, input logic [7:0] b);
    ram[a]     = b;
    ref_mem[a] = b;
  endtask

  task automatic do_op(input logic wr, input logic rd, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] l, input logic s,
                       input string tag);
    int          n = len_n(l);
    int          exp_lat;
    int          cyc = 0;
    int          wcnt = 0;
    bit          done = 0;
    logic [31:0] exp_data;
    exp_lat  = wr ? n + 1 : n + 2;
    exp_data = wr ? 32'd0 : model_load(a, l, s);
    ram_write = wr; ram_read = rd; ram_addr = a; ram_data_i = d;
    ram_length = l; ram_signed = s;
    while (!done && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 1) begin
        ram_addr = $urandom; ram_data_i = $urandom;
        ram_length = 3'($urandom); ram_signed = 1'($urandom);
      end
      check({tag, " busy"}, 32'(ram_busy), 32'd1);
      if (mem_wr) begin
        check({tag, " wr_addr"}, 32'(mem_a), (a + 32'(wcnt)) % SIZE);
        if (wcnt < 4) begin
          check({tag, " wr_byte"}, 32'(mem_dout), 32'(d[8*wcnt +: 8]));
          ref_mem[(a + 32'(wcnt)) % SIZE] = d[8*wcnt +: 8];
        end
        wcnt++;
      end
      if (ram_ready) begin
        done = 1;
        check({tag, " latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, " data"}, ram_data_o, exp_data);
        check({tag, " wr_count"}, 32'(wcnt), wr ? 32'(n) : 32'd0);
        ram_read = 1'b0; ram_write = 1'b0;
      end
    end
    if (!done) begin
      check({tag, " ready_timeout"}, 32'd0, 32'd1);
      ram_read = 1'b0; ram_write = 1'b0;
    end
    @(posedge clk); #1;
    check({tag, " idle_busy"}, 32'(ram_busy), 32'd0);
    check({tag, " idle_ready"}, 32'(ram_ready), 32'd0);
    check({tag, " data_hold"}, ram_data_o, exp_data);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [2:0]  l;
    logic        s;
    int          op;
    for (int i = 0; i < SIZE; i++) poke(i, 8'($urandom));
    reset = 1'b1; ram_read = 1'b0; ram_write = 1'b0; ram_addr = 32'd0;
    ram_data_i = 32'd0; ram_length = 3'd0; ram_signed = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy",  32'(ram_busy),  32'd0);
    check("rst ready", 32'(ram_ready), 32'd0);
    check("rst data",  ram_data_o,     32'd0);
    check("rst mem_a", 32'(mem_a),     32'd0);
    check("rst dout",  32'(mem_dout),  32'd0);
    check("rst wr",    32'(mem_wr),    32'd0);
    reset = 1'b0;

    // Directed loads
    poke(32'h100, 8'h78); poke(32'h101, 8'h56); poke(32'h102, 8'h34); poke(32'h103, 8'h12);
    do_op(1'b0, 1'b1, 32'h100, 32'd0, 3'd4, 1'b0, "lw");
    check("lw value", ram_data_o, 32'h1234_5678);
    poke(32'h200, 8'h80);
    do_op(1'b0, 1'b1, 32'h200, 32'd0, 3'd1, 1'b1, "lb");
    check("lb value", ram_data_o, 32'hFFFF_FF80);
    do_op(1'b0, 1'b1, 32'h200, 32'd0, 3'd1, 1'b0, "lbu");
    check("lbu value", ram_data_o, 32'h0000_0080);
    poke(32'h202, 8'h34); poke(32'h203, 8'hF2);
    do_op(1'b0, 1'b1, 32'h202, 32'd0, 3'd2, 1'b1, "lh");
    check("lh value", ram_data_o, 32'hFFFF_F234);

    // Directed stores with read-back
    do_op(1'b1, 1'b0, 32'h10, 32'hDEAD_BEEF, 3'd4, 1'b0, "sw");
    do_op(1'b0, 1'b1, 32'h10, 32'd0, 3'd4, 1'b0, "sw_rb");
    check("sw readback", ram_data_o, 32'hDEAD_BEEF);
    do_op(1'b1, 1'b0, 32'(SIZE - 1), 32'h0000_AABB, 3'd2, 1'b0, "sh_wrap");
    do_op(1'b0, 1'b1, 32'(SIZE - 1), 32'd0, 3'd2, 1'b0, "sh_rb");
    check("sh wrap readback", ram_data_o, 32'h0000_AABB);

    // Both requests high: the write takes priority
    do_op(1'b1, 1'b1, 32'h300, 32'hCAFE_F00D, 3'd4, 1'b1, "both");
    do_op(1'b0, 1'b1, 32'h300, 32'd0, 3'd4, 1'b0, "both_rb");
    check("both readback", ram_data_o, 32'hCAFE_F00D);

    // Reset during the second byte of a word store
    ram_write = 1'b1; ram_addr = 32'h400; ram_data_i = 32'h1122_3344; ram_length = 3'd4;
    @(posedge clk); #1;
    check("rstwr c0 wr", 32'(mem_wr), 32'd1);
    @(posedge clk); #1;
    check("rstwr c1 wr", 32'(mem_wr), 32'd1);
    check("rstwr c1 addr", 32'(mem_a), 32'h401);
    ref_mem[32'h400] = 8'h44;
    ref_mem[32'h401] = 8'h33;
    reset = 1'b1; ram_write = 1'b0;
    @(posedge clk); #1;
    check("rstwr busy",  32'(ram_busy),  32'd0);
    check("rstwr wr",    32'(mem_wr),    32'd0);
    check("rstwr ready", 32'(ram_ready), 32'd0);
    reset = 1'b0;
    do_op(1'b0, 1'b1, 32'h400, 32'd0, 3'd4, 1'b0, "rstwr_rb");

    // Randomized traffic, biased toward the wrap boundary
    for (int k = 0; k < 60; k++) begin
      a = $urandom;
      if (k % 4 == 0) a = 32'(SIZE - 1 - $urandom_range(0, 2));
      d  = $urandom;
      l  = 3'($urandom);
      s  = 1'($urandom);
      op = $urandom_range(0, 2);
      do_op(op != 0, op != 1, a, d, l, s, "rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
